// File: rtl/sha256_w_schedule_issuer.sv
// SHA-256 message schedule issuer: emits W[0..NUM_WORDS-1] over valid/ready.
// Optional w_last output is compiled in when SHA256_W_LAST_EN is defined.
module sha256_w_schedule_issuer #(
  parameter int NUM_WORDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_index,
`ifdef SHA256_W_LAST_EN
  output logic         w_last,
`endif
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic        load;
  logic        xfer;
  logic [31:0] win [16];
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window holds W[t..t+15]; the next word extends it by W[t+16].
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign w_out = win[0];

`ifdef SHA256_W_LAST_EN
  assign w_last = w_valid && (w_index == LAST_IDX);
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    w_valid   = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    xfer      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        w_valid = 1'b1;
        if (w_ready) begin
          xfer = 1'b1;
          if (w_index == LAST_IDX) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sliding window and index: load on accept, shift on transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      w_index <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
      w_index <= '0;
    end else if (xfer) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
      w_index <= w_index + 6'd1;
    end
  end

endmodule

// File: tb/tb_sha256_w_schedule_issuer.sv
// Testbench for sha256_w_schedule_issuer against an array-based model.
// Define SHA256_W_LAST_EN to also cover the w_last output.
module tb_sha256_w_schedule_issuer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic         w_ready;
  logic [511:0] block_in;
  logic         busy, w_valid, done;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
`ifdef SHA256_W_LAST_EN
  logic         w_last;
  logic         s_last;
`endif
  logic         s_start, s_ready;
  logic [511:0] s_block;
  logic         s_busy, s_valid, s_done;
  logic [31:0]  s_out;
  logic [5:0]   s_index;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  int          got_i [64];
  int nwords, ndone, stall_bad, last_bad, rst_bad, gap;
  bit tmo;

  always #5 CLK = ~CLK;

  sha256_w_schedule_issuer dut (
    .CLK(CLK), .RST(RST), .start(start), .block_in(block_in),
    .busy(busy), .w_valid(w_valid), .w_ready(w_ready),
    .w_out(w_out), .w_index(w_index),
`ifdef SHA256_W_LAST_EN
    .w_last(w_last),
`endif
    .done(done)
  );

  sha256_w_schedule_issuer #(.NUM_WORDS(16)) dut16 (
    .CLK(CLK), .RST(RST), .start(s_start), .block_in(s_block),
    .busy(s_busy), .w_valid(s_valid), .w_ready(s_ready),
    .w_out(s_out), .w_index(s_index),
`ifdef SHA256_W_LAST_EN
    .w_last(s_last),
`endif
    .done(s_done)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
    return r;
  endfunction

  task automatic build_model(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        exp_w[t] = 32'(b >> (32 * (15 - t)));
      end else begin
        s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
        s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
        exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
      end
    end
  endtask

  task automatic kick(input logic [511:0] b);
    @(negedge CLK);
    start    = 1'b1;
    block_in = b;
    w_ready  = 1'b1;
  endtask

  // Consumer: records transferred words, optional stall/poke/reset events.
  task automatic collect(input int stall_t, input int stall_len,
                         input int poke_t, input int rst_t, input bit rnd);
    int left, last_cyc;
    bit stalled, poked;
    logic [31:0] hw;
    logic [5:0]  hi;
    nwords = 0; ndone = 0; stall_bad = 0; last_bad = 0;
    rst_bad = 0; gap = -1; tmo = 1'b1;
    left = 0; last_cyc = -10; stalled = 0; poked = 0;
    hw = '0; hi = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      start = 1'b0;
`ifdef SHA256_W_LAST_EN
      if (w_last !== (w_valid && w_index == 6'd63)) last_bad++;
`endif
      if (done) begin
        ndone++;
        gap = c - last_cyc;
        tmo = 1'b0;
        break;
      end
      if (w_valid && rst_t == int'(w_index)) begin
        RST = 1'b1;
        #1;
        if ({busy, w_valid, done, w_out, w_index} !== '0) rst_bad++;
`ifdef SHA256_W_LAST_EN
        if (w_last !== 1'b0) rst_bad++;
`endif
        @(negedge CLK);
        RST = 1'b0;
        tmo = 1'b0;
        break;
      end
      if (w_valid && poke_t == int'(w_index) && !poked) begin
        poked    = 1'b1;
        start    = 1'b1;
        block_in = rand_block();
      end
      if (w_valid && stall_t == int'(w_index) && !stalled) begin
        stalled = 1'b1;
        left    = stall_len;
        hw      = w_out;
        hi      = w_index;
      end
      if (stalled && w_index == hi && w_out !== hw) stall_bad++;
      if (left > 0) begin
        w_ready = 1'b0;
        left--;
      end else begin
        w_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (w_valid && w_ready) begin
        if (nwords < 64) begin
          got_w[nwords] = w_out;
          got_i[nwords] = int'(w_index);
        end
        nwords++;
        last_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; w_ready = 1'b0; block_in = '0;
    s_start = 1'b0; s_ready = 1'b0; s_block = '0;
    @(negedge CLK);
    @(negedge CLK);
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy got=%0d exp=0", busy); errors++;
    end
    checks++;
    if (w_valid !== 1'b0) begin
      $display("FAIL reset_valid got=%0d exp=0", w_valid); errors++;
    end
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL reset_done got=%0d exp=0", done); errors++;
    end
    checks++;
    if (w_out !== 32'h0) begin
      $display("FAIL reset_wout got=%h exp=0", w_out); errors++;
    end
    checks++;
    if (w_index !== 6'd0) begin
      $display("FAIL reset_index got=%0d exp=0", w_index); errors++;
    end
    checks++;
`ifdef SHA256_W_LAST_EN
    if (w_last !== 1'b0) begin
      $display("FAIL reset_last got=%0d exp=0", w_last); errors++;
    end
    checks++;
`endif
    RST = 1'b0;
  endtask

  task automatic test_abc();
    logic [511:0] b;
    b = {32'h61626380, 448'h0, 32'h00000018};
    build_model(b);
    kick(b);
    collect(-1, 0, -1, -1, 1'b0);
    if (got_w[0] !== 32'h61626380) begin
      $display("FAIL abc_w0 got=%h exp=61626380", got_w[0]); errors++;
    end
    checks++;
    if (got_w[15] !== 32'h00000018) begin
      $display("FAIL abc_w15 got=%h exp=00000018", got_w[15]); errors++;
    end
    checks++;
    if (got_w[16] !== 32'h61626380) begin
      $display("FAIL abc_w16 got=%h exp=61626380", got_w[16]); errors++;
    end
    checks++;
    if (got_w[17] !== 32'h000F0000) begin
      $display("FAIL abc_w17 got=%h exp=000f0000", got_w[17]); errors++;
    end
    checks++;
    for (int t = 0; t < 64; t++) begin
      if (got_w[t] !== exp_w[t] || got_i[t] != t) begin
        $display("FAIL abc_word t=%0d got=%h/%0d exp=%h/%0d",
                 t, got_w[t], got_i[t], exp_w[t], t);
        errors++;
      end
      checks++;
    end
    if (tmo || nwords != 64 || ndone != 1 || gap != 1) begin
      $display("FAIL abc_done tmo=%0d n=%0d done=%0d gap=%0d exp 0/64/1/1",
               tmo, nwords, ndone, gap);
      errors++;
    end
    checks++;
    @(negedge CLK);
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL abc_idle busy=%0d done=%0d exp 0/0", busy, done);
      errors++;
    end
    checks++;
  endtask

  task automatic test_stall();
    logic [511:0] b;
    b = rand_block();
    build_model(b);
    kick(b);
    collect(20, 5, -1, -1, 1'b0);
    if (stall_bad != 0) begin
      $display("FAIL stall_hold got=%0d changes exp=0", stall_bad); errors++;
    end
    checks++;
    for (int t = 0; t < 64; t++) begin
      if (got_w[t] !== exp_w[t] || got_i[t] != t) begin
        $display("FAIL stall_word t=%0d got=%h/%0d exp=%h/%0d",
                 t, got_w[t], got_i[t], exp_w[t], t);
        errors++;
      end
      checks++;
    end
    if (tmo || nwords != 64 || ndone != 1 || gap != 1) begin
      $display("FAIL stall_done tmo=%0d n=%0d done=%0d gap=%0d exp 0/64/1/1",
               tmo, nwords, ndone, gap);
      errors++;
    end
    checks++;
  endtask

  task automatic test_start_in_run();
    logic [511:0] b;
    b = rand_block();
    build_model(b);
    kick(b);
    collect(-1, 0, 10, -1, 1'b1);
    for (int t = 0; t < 64; t++) begin
      if (got_w[t] !== exp_w[t] || got_i[t] != t) begin
        $display("FAIL poke_word t=%0d got=%h/%0d exp=%h/%0d",
                 t, got_w[t], got_i[t], exp_w[t], t);
        errors++;
      end
      checks++;
    end
    if (tmo || nwords != 64 || ndone != 1) begin
      $display("FAIL poke_done tmo=%0d n=%0d done=%0d exp 0/64/1",
               tmo, nwords, ndone);
      errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [511:0] b;
    b = rand_block();
    build_model(b);
    kick(b);
    collect(-1, 0, -1, 30, 1'b0);
    if (rst_bad != 0 || ndone != 0 || tmo) begin
      $display("FAIL rstmid_zero bad=%0d done=%0d tmo=%0d exp 0/0/0",
               rst_bad, ndone, tmo);
      errors++;
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0) begin
        $display("FAIL rstmid_quiet done=%0d busy=%0d valid=%0d exp 0/0/0",
                 done, busy, w_valid);
        errors++;
      end
      checks++;
    end
    kick(b);
    collect(-1, 0, -1, -1, 1'b1);
    for (int t = 0; t < 64; t++) begin
      if (got_w[t] !== exp_w[t] || got_i[t] != t) begin
        $display("FAIL rstmid_word t=%0d got=%h/%0d exp=%h/%0d",
                 t, got_w[t], got_i[t], exp_w[t], t);
        errors++;
      end
      checks++;
    end
    if (tmo || nwords != 64 || ndone != 1) begin
      $display("FAIL rstmid_done tmo=%0d n=%0d done=%0d exp 0/64/1",
               tmo, nwords, ndone);
      errors++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [511:0] b1, b2;
    b1 = rand_block();
    b2 = rand_block();
    build_model(b1);
    kick(b1);
    collect(-1, 0, -1, -1, 1'b1);
    for (int t = 0; t < 64; t++) begin
      if (got_w[t] !== exp_w[t]) begin
        $display("FAIL b2b_first t=%0d got=%h exp=%h", t, got_w[t], exp_w[t]);
        errors++;
      end
      checks++;
    end
    start    = 1'b1;
    block_in = b2;
    @(negedge CLK);
    if (busy !== 1'b0 || w_valid !== 1'b0) begin
      $display("FAIL b2b_gap busy=%0d valid=%0d exp 0/0", busy, w_valid);
      errors++;
    end
    checks++;
    build_model(b2);
    collect(-1, 0, -1, -1, 1'b1);
    for (int t = 0; t < 64; t++) begin
      if (got_w[t] !== exp_w[t] || got_i[t] != t) begin
        $display("FAIL b2b_second t=%0d got=%h/%0d exp=%h/%0d",
                 t, got_w[t], got_i[t], exp_w[t], t);
        errors++;
      end
      checks++;
    end
    if (tmo || nwords != 64 || ndone != 1) begin
      $display("FAIL b2b_done tmo=%0d n=%0d done=%0d exp 0/64/1",
               tmo, nwords, ndone);
      errors++;
    end
    checks++;
  endtask

  task automatic test_stall_last();
    logic [511:0] b;
    b = rand_block();
    build_model(b);
    kick(b);
    collect(63, 3, -1, -1, 1'b1);
    if (got_w[63] !== exp_w[63] || stall_bad != 0) begin
      $display("FAIL last_word got=%h exp=%h holdbad=%0d",
               got_w[63], exp_w[63], stall_bad);
      errors++;
    end
    checks++;
`ifdef SHA256_W_LAST_EN
    if (last_bad != 0) begin
      $display("FAIL w_last got=%0d bad cycles exp=0", last_bad); errors++;
    end
    checks++;
`endif
  endtask

  task automatic test_short();
    logic [511:0] b;
    logic [31:0]  sw [16];
    int si [16];
    int n, sgap, last_c;
    bit seen;
    b = rand_block();
    n = 0; sgap = -1; last_c = -10; seen = 0;
    @(negedge CLK);
    s_start = 1'b1;
    s_block = b;
    s_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      s_start = 1'b0;
      if (s_done) begin
        seen = 1'b1;
        sgap = c - last_c;
        break;
      end
      if (s_valid) begin
        if (n < 16) begin
          sw[n] = s_out;
          si[n] = int'(s_index);
        end
        n++;
        last_c = c;
      end
    end
    for (int t = 0; t < 16; t++) begin
      if (sw[t] !== 32'(b >> (32 * (15 - t))) || si[t] != t) begin
        $display("FAIL short_word t=%0d got=%h/%0d exp=%h/%0d",
                 t, sw[t], si[t], 32'(b >> (32 * (15 - t))), t);
        errors++;
      end
      checks++;
    end
    if (!seen || n != 16 || sgap != 1) begin
      $display("FAIL short_done seen=%0d n=%0d gap=%0d exp 1/16/1",
               seen, n, sgap);
      errors++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_start_in_run();
    test_reset_mid();
    test_back_to_back();
    test_stall_last();
    for (int r = 0; r < 2; r++) test_start_in_run();
    test_short();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
